// File: rtl/ps2_word_packer_if.sv
// ---------------------------------------------------------------------------
// ps2_word_packer_if
// Word delivery channel from the PS/2 word packer to the DMA engine.
//
// Handshake: the packer (master) holds out_valid high while out_word and
// out_count present the FIFO head word. A transfer happens on every rising
// clock edge where out_valid && out_ready. While out_valid=1 and out_ready=0
// the master keeps out_word/out_count stable. out_valid does not depend on
// out_ready.
//
// Signals:
//   out_word  - head word (BYTE_W*BYTES_PER_WORD bits), master -> slave
//   out_count - number of valid bytes in out_word, master -> slave
//   out_valid - head word present, master -> slave
//   out_ready - slave accepts head word, slave -> master
// ---------------------------------------------------------------------------
interface ps2_word_packer_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 3
);
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;

  modport master (output out_word, output out_count, output out_valid,
                  input  out_ready);
  modport slave  (input  out_word, input  out_count, input  out_valid,
                  output out_ready);
endinterface

// File: rtl/ps2_word_packer.sv
// ---------------------------------------------------------------------------
// ps2_word_packer
// Packs BYTES_PER_WORD PS/2 scan-code bytes into one word and queues finished
// words (with a byte count) in a first-word-fall-through FIFO for the DMA.
// Supports MSB-first or LSB-first lane order, flushing of partial words,
// backpressure from the DMA and sticky overflow detection.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous active-high reset, clears all state
//   tick     - one-cycle byte strobe, d valid when high
//   d        - scan-code byte
//   flush    - commit the partially assembled word (zero-padded)
//   dma      - word channel (master): out_word/out_count/out_valid/out_ready
//   byte_cnt - bytes currently held in the assembly register
//   level    - words queued in the FIFO
//   full     - FIFO holds FIFO_DEPTH words
//   listo    - one-cycle pulse after every commit edge (also dropped ones)
//   overflow - sticky: a committed word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module ps2_word_packer #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int MSB_FIRST      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              tick,
  input  logic [BYTE_W-1:0]                 d,
  input  logic                              flush,
  ps2_word_packer_if.master                 dma,
  output logic [$clog2(BYTES_PER_WORD)-1:0] byte_cnt,
  output logic [$clog2(FIFO_DEPTH):0]       level,
  output logic                              full,
  output logic                              listo,
  output logic                              overflow
);
  localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
  localparam int BC_W   = $clog2(BYTES_PER_WORD);
  localparam int CNT_W  = BC_W + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;

  // Assembly state
  logic [WORD_W-1:0] r_asm;
  logic [BC_W-1:0]   r_byte_cnt;

  // FIFO state; level is tracked explicitly so full and empty are unambiguous
  logic [WORD_W-1:0] r_mem_word [FIFO_DEPTH];
  logic [CNT_W-1:0]  r_mem_cnt  [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_listo;
  logic              r_overflow;

  logic [BC_W-1:0]   w_lane;
  logic [WORD_W-1:0] w_asm_next;
  logic [CNT_W-1:0]  w_cnt_after;
  logic              w_commit;
  logic              w_nonempty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;

  // Lane receiving the current byte
  assign w_lane = (MSB_FIRST != 0) ? (BC_W'(BYTES_PER_WORD - 1) - r_byte_cnt)
                                   : r_byte_cnt;

  // Assembly word including this cycle's byte, so a commit on the same edge
  // as the last (or flushed) tick already contains d.
  always_comb begin
    w_asm_next = r_asm;
    for (int l = 0; l < BYTES_PER_WORD; l++) begin
      if (tick && (w_lane == BC_W'(l))) begin
        w_asm_next[l*BYTE_W +: BYTE_W] = d;
      end
    end
  end

  assign w_cnt_after = CNT_W'(r_byte_cnt) + CNT_W'(tick);

  // A full word completes on the last tick; a flush commits whenever at least
  // one byte (held or arriving now) is present.
  assign w_commit = (tick && (r_byte_cnt == BC_W'(BYTES_PER_WORD - 1))) ||
                    (flush && (tick || (r_byte_cnt != '0)));

  assign w_nonempty = (r_level != '0);
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  // Pop only a word that is already visible: a word pushed into an empty FIFO
  // is not popped on the same edge.
  assign w_pop      = w_nonempty && dma.out_ready;
  // A pop on the same edge frees the slot, so push is allowed even when full.
  assign w_push     = w_commit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_listo    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_commit) begin
        r_asm      <= '0;
        r_byte_cnt <= '0;
      end else begin
        r_asm <= w_asm_next;
        if (tick) begin
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
        end
      end

      r_listo <= w_commit;

      if (w_push) begin
        r_mem_word[r_wr_ptr] <= w_asm_next;
        r_mem_cnt[r_wr_ptr]  <= w_cnt_after;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LVL_W'(1);
      end

      if (w_commit && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head word is forced to zero when empty so stale storage never shows.
  assign dma.out_valid = w_nonempty;
  assign dma.out_word  = w_nonempty ? r_mem_word[r_rd_ptr] : '0;
  assign dma.out_count = w_nonempty ? r_mem_cnt[r_rd_ptr]  : '0;

  assign byte_cnt = r_byte_cnt;
  assign level    = r_level;
  assign full     = w_full;
  assign listo    = r_listo;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_ps2_word_packer.sv
// ---------------------------------------------------------------------------
// tb_ps2_word_packer
// Two packers (MSB-first and LSB-first) share the same stimulus. A vector
// table covers basic packing and flush behaviour; hand-written sequences
// cover overflow, full-FIFO push/pop and reset during assembly.
// ---------------------------------------------------------------------------
module tb_ps2_word_packer;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic [7:0] d     = 8'h00;
  logic       flush = 1'b0;
  logic       ready = 1'b0;

  ps2_word_packer_if #(.WORD_W(32), .CNT_W(3)) bus_msb ();
  ps2_word_packer_if #(.WORD_W(32), .CNT_W(3)) bus_lsb ();
  assign bus_msb.out_ready = ready;
  assign bus_lsb.out_ready = ready;

  logic [1:0] bc_m, bc_l;
  logic [2:0] lvl_m, lvl_l;
  logic       full_m, full_l, listo_m, listo_l, ovf_m, ovf_l;

  ps2_word_packer #(.BYTE_W(8), .BYTES_PER_WORD(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .tick(tick), .d(d), .flush(flush), .dma(bus_msb),
    .byte_cnt(bc_m), .level(lvl_m), .full(full_m), .listo(listo_m), .overflow(ovf_m));

  ps2_word_packer #(.BYTE_W(8), .BYTES_PER_WORD(4), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .tick(tick), .d(d), .flush(flush), .dma(bus_lsb),
    .byte_cnt(bc_l), .level(lvl_l), .full(full_l), .listo(listo_l), .overflow(ovf_l));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic with_tick);
    reset = 1'b1;
    tick  = with_tick;
    d     = 8'hEE;
    flush = 1'b0;
    step();
    reset = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    tick = 1'b1;
    d    = b;
    step();
    tick = 1'b0;
  endtask

  // Pop everything, comparing against exp_q; bounded by a cycle budget.
  task automatic drain(input string name);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!bus_msb.out_valid) break;
      if (exp_q.size() == 0) begin
        chk({name, "_extra_word"}, bus_msb.out_word, 32'hDEADBEEF);
      end else begin
        chk({name, "_word"}, bus_msb.out_word, exp_q.pop_front());
      end
      step();
    end
    chk({name, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_level_after"}, 32'(lvl_m), 32'd0);
    ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        tick;
    logic [7:0]  d;
    logic        flush;
    logic        ready;
    logic        valid;
    logic [31:0] word;
    logic [31:0] lword;
    logic [2:0]  cnt;
    logic [1:0]  bc;
    logic [2:0]  lvl;
    logic        listo;
  } vec_t;

  vec_t vec [9];

  initial begin
    //           tick  d      flush ready valid word          lword         cnt   bc    lvl   listo
    vec[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd1, 3'd0, 1'b0};
    vec[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd2, 3'd0, 1'b0};
    vec[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd3, 3'd0, 1'b0};
    vec[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h11223344, 32'h44332211, 3'd4, 2'd0, 3'd1, 1'b1};
    vec[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd0, 3'd0, 1'b0};
    vec[5] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd1, 3'd0, 1'b0};
    vec[6] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd2, 3'd0, 1'b0};
    vec[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'hAABB0000, 32'h0000BBAA, 3'd2, 2'd0, 3'd1, 1'b1};
    vec[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        32'h0,        3'd0, 2'd0, 3'd0, 1'b0};

    // ---- reset state ----
    do_reset(1'b0);
    chk("rst_valid", 32'(bus_msb.out_valid), 32'd0);
    chk("rst_word", bus_msb.out_word, 32'd0);
    chk("rst_count", 32'(bus_msb.out_count), 32'd0);
    chk("rst_byte_cnt", 32'(bc_m), 32'd0);
    chk("rst_level", 32'(lvl_m), 32'd0);
    chk("rst_full", 32'(full_m), 32'd0);
    chk("rst_listo", 32'(listo_m), 32'd0);
    chk("rst_overflow", 32'(ovf_m), 32'd0);

    // ---- table-driven packing and flush ----
    for (int i = 0; i < 9; i++) begin
      tick  = vec[i].tick;
      d     = vec[i].d;
      flush = vec[i].flush;
      ready = vec[i].ready;
      step();
      tick  = 1'b0;
      flush = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(bus_msb.out_valid), 32'(vec[i].valid));
      chk($sformatf("v%0d_word", i), bus_msb.out_word, vec[i].word);
      chk($sformatf("v%0d_lsb_word", i), bus_lsb.out_word, vec[i].lword);
      chk($sformatf("v%0d_count", i), 32'(bus_msb.out_count), 32'(vec[i].cnt));
      chk($sformatf("v%0d_byte_cnt", i), 32'(bc_m), 32'(vec[i].bc));
      chk($sformatf("v%0d_level", i), 32'(lvl_m), 32'(vec[i].lvl));
      chk($sformatf("v%0d_listo", i), 32'(listo_m), 32'(vec[i].listo));
    end
    ready = 1'b0;

    // ---- overflow: 5 words into a 4-deep FIFO with no DMA ready ----
    do_reset(1'b0);
    for (int k = 1; k <= 20; k++) begin
      send(8'(k));
      if (k == 16) begin
        chk("ovf_full_at_4", 32'(full_m), 32'd1);
        chk("ovf_not_yet", 32'(ovf_m), 32'd0);
      end
    end
    chk("ovf_level", 32'(lvl_m), 32'd4);
    chk("ovf_full", 32'(full_m), 32'd1);
    chk("ovf_flag", 32'(ovf_m), 32'd1);
    chk("ovf_byte_cnt", 32'(bc_m), 32'd0);
    chk("ovf_listo_dropped", 32'(listo_m), 32'd1);
    chk("ovf_head_stable", bus_msb.out_word, 32'h01020304);
    exp_q.push_back(32'h01020304);
    exp_q.push_back(32'h05060708);
    exp_q.push_back(32'h090A0B0C);
    exp_q.push_back(32'h0D0E0F10);
    drain("ovf_drain");
    chk("ovf_sticky", 32'(ovf_m), 32'd1);

    // ---- full FIFO: push and pop on the same edge ----
    do_reset(1'b0);
    chk("full_rst_ovf_clear", 32'(ovf_m), 32'd0);
    for (int k = 1; k <= 16; k++) send(8'(k));
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    ready = 1'b1;
    send(8'hA4);
    ready = 1'b0;
    chk("pp_level", 32'(lvl_m), 32'd4);
    chk("pp_overflow", 32'(ovf_m), 32'd0);
    chk("pp_listo", 32'(listo_m), 32'd1);
    exp_q.push_back(32'h05060708);
    exp_q.push_back(32'h090A0B0C);
    exp_q.push_back(32'h0D0E0F10);
    exp_q.push_back(32'hA1A2A3A4);
    drain("pp_drain");

    // ---- reset mid-word, then flush together with a tick ----
    send(8'h55);
    send(8'h66);
    do_reset(1'b1);  // tick during reset must be ignored
    chk("mid_rst_byte_cnt", 32'(bc_m), 32'd0);
    chk("mid_rst_valid", 32'(bus_msb.out_valid), 32'd0);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'h04);
    chk("clean_word", bus_msb.out_word, 32'h01020304);
    chk("clean_count", 32'(bus_msb.out_count), 32'd4);
    ready = 1'b1;
    step();
    ready = 1'b0;
    chk("clean_popped", 32'(lvl_m), 32'd0);
    send(8'h77);
    chk("ft_byte_cnt1", 32'(bc_m), 32'd1);
    flush = 1'b1;
    send(8'h88);
    flush = 1'b0;
    chk("ft_word", bus_msb.out_word, 32'h77880000);
    chk("ft_lsb_word", bus_lsb.out_word, 32'h00008877);
    chk("ft_count", 32'(bus_msb.out_count), 32'd2);
    chk("ft_listo", 32'(listo_m), 32'd1);
    chk("ft_byte_cnt0", 32'(bc_m), 32'd0);
    step();
    chk("ft_listo_one_cycle", 32'(listo_m), 32'd0);
    chk("ft_head_held", bus_msb.out_word, 32'h77880000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/ps2_word_packer.md
Name: ps2_word_packer

Overview:
Parametrised successor to the PS/2 keyboard byte buffer. It packs BYTES_PER_WORD scan-code bytes into one word and queues completed words in a small first-word-fall-through FIFO. Each FIFO word carries a byte count. Words are delivered to the DMA module over a valid/ready handshake. Unlike the fixed 4x8 version, it adds a selectable byte order, a flush of partial words, backpressure handling and overflow detection.

Parameters:
BYTE_W, 8, width of one scan-code byte
BYTES_PER_WORD, 4, bytes per packed word (2..8)
FIFO_DEPTH, 4, number of words queued (power of 2, >=2)
MSB_FIRST, 1, 1: first byte goes to the most-significant lane; 0: first byte goes to lane 0 (LSB)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears all state
tick  in  1  byte strobe, one-cycle pulse, d valid when high
d  in  BYTE_W  scan-code byte from keyboard receiver
flush  in  1  commit a partially assembled word (zero-padded)
out_word  out  BYTE_W*BYTES_PER_WORD  FIFO head word to DMA
out_count  out  clog2(BYTES_PER_WORD)+1  valid bytes in out_word (1..BYTES_PER_WORD)
out_valid  out  1  FIFO not empty
out_ready  in  1  DMA accepts head word
byte_cnt  out  clog2(BYTES_PER_WORD)  bytes held in assembly register
level  out  clog2(FIFO_DEPTH)+1  words in FIFO
full  out  1  level == FIFO_DEPTH
listo  out  1  one-cycle pulse after a word is committed to the FIFO
overflow  out  1  sticky: a committed word was dropped

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Assembly register, byte_cnt, FIFO pointers, level, listo and overflow all go to 0.
  - out_valid=0 and full=0. out_word and out_count read 0.
  - Reset mid-word discards the partial word.
- Assembly:
  - On tick, d is written to lane byte_cnt. With MSB_FIRST=1 this is lane index BYTES_PER_WORD-1-byte_cnt; with MSB_FIRST=0 it is lane index byte_cnt.
  - byte_cnt then increments.
  - Lanes not yet written hold 0.
- Commit (full word): on a tick with byte_cnt==BYTES_PER_WORD-1, the same edge does all of the following:
  - pushes the completed word (including d) to the FIFO with count BYTES_PER_WORD;
  - clears the assembly register;
  - sets byte_cnt to 0.
- Commit (flush):
  - flush with byte_cnt>0 and no tick pushes the zero-padded word with count=byte_cnt, then clears assembly.
  - flush and tick in the same cycle: d is included first, then the word is committed with count=byte_cnt+1. If that makes a full word, it behaves as a normal full-word commit.
  - flush with byte_cnt==0 and no tick is a no-op.
- listo: registered, high for exactly one cycle after every commit edge, including dropped commits.
- Latency: for a commit at edge N with the FIFO previously empty, out_valid=1 and out_word/out_count are valid in the cycle after edge N.
- FIFO:
  - First-word-fall-through; out_valid = (level != 0).
  - Pop occurs when out_valid && out_ready at a clk edge.
  - out_word and out_count must not change while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Allowed at any level, including full; level is unchanged and there is no overflow.
  - Push while level==0 and out_ready=1: the word is not popped that edge (FWFT, appears next cycle).
- Overflow:
  - A commit while full with no pop that edge drops the word; level is unchanged and the FIFO contents are unchanged.
  - overflow sets to 1 and stays set until reset. Assembly is still cleared and byte_cnt goes to 0.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. level is tracked explicitly (0..FIFO_DEPTH).
- tick while reset=1 is ignored.

Test Plan:
- Default params, out_ready=1, ticks with d=0x11,0x22,0x33,0x44 -> listo pulses once; out_valid next cycle; out_word=0x11223344, out_count=4; popped, level returns to 0.
- MSB_FIRST=0, same bytes -> out_word=0x44332211, out_count=4.
- Ticks 0xAA,0xBB, then flush alone -> out_word=0xAABB0000, out_count=2, byte_cnt=0. A further flush with byte_cnt=0 -> no push, no listo.
- out_ready=0, 20 bytes (5 words) -> level=4, full=1, overflow=1 after the 5th commit. Draining yields exactly words 1..4 in order, and overflow stays 1.
- FIFO full, 4th byte tick coinciding with out_ready=1 -> level stays 4, overflow stays 0, new word appears last in order.
- reset after 2 bytes, then 0x01,0x02,0x03,0x04 -> byte_cnt=0 after reset; out_word=0x01020304 with no stale bytes; flush+tick same cycle at byte_cnt=1 -> out_count=2.
